// File: rtl/mem_stage_cache_pkg.sv
// Shared types and address-field geometry for the MEM-stage two-way data cache.
package mem_cache_pkg;

    localparam int unsigned SETS_DEF = 64;
    localparam int unsigned OFF_POS  = 2;
    localparam int unsigned OFF_W    = 1;
    localparam int unsigned IDX_W    = $clog2(SETS_DEF);
    localparam int unsigned TAG_W    = 32 - IDX_W - OFF_W - OFF_POS;
    localparam int unsigned IDX_LSB  = OFF_POS + OFF_W;
    localparam int unsigned TAG_LSB  = IDX_LSB + IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL0,
        ST_FILL1,
        ST_WRITE,
        ST_WDONE
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      word1;
        logic [31:0]      word0;
    } line_t;

    function automatic line_t put_word(input line_t l, input logic sel, input logic [31:0] w);
        line_t r;
        r = l;
        if (sel) r.word1 = w;
        else     r.word0 = w;
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_cache_way_array.sv
// One cache way: valid/tag/two-word storage, asynchronous read, single write port.
module cache_way_array
    import mem_cache_pkg::*;
#(
    parameter int unsigned SETS = SETS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output line_t            rd_line,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  line_t            wr_line
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q   [SETS];
    logic [31:0]      word0_q [SETS];
    logic [31:0]      word1_q [SETS];

    // Only the valid bits need reset; tag/data are don't-care until validated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= wr_line.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]   <= wr_line.tag;
            word0_q[wr_idx] <= wr_line.word0;
            word1_q[wr_idx] <= wr_line.word1;
        end
    end

    always_comb begin
        rd_line       = '0;
        rd_line.valid = valid_q[rd_idx];
        rd_line.tag   = tag_q[rd_idx];
        rd_line.word0 = word0_q[rd_idx];
        rd_line.word1 = word1_q[rd_idx];
    end

endmodule

// File: rtl/mem_stage_cache.sv
// Two-way write-through, no-write-allocate MEM-stage data cache with SRAM fill/write FSM.
module mem_stage_cache
    import mem_cache_pkg::*;
#(
    parameter int unsigned SETS = SETS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_en,
    input  logic        MEM_W_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        cache_freeze,
    output logic        sram_rd,
    output logic        sram_wr,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    state_e           state_q, state_d;
    logic [SETS-1:0]  lru_q, lru_d;
    logic [31:0]      fill_q, fill_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             word_sel;
    line_t            line0, line1, wr_line;
    logic             hit0, hit1, hit, we0, we1;
    logic             unused_addr_lsb;

    assign idx             = addr[IDX_LSB +: IDX_W];
    assign tag             = addr[TAG_LSB +: TAG_W];
    assign word_sel        = addr[OFF_POS];
    assign unused_addr_lsb = ^addr[1:0];

    cache_way_array #(.SETS(SETS)) u_way0 (
        .clk(clk), .rst(rst), .rd_idx(idx), .rd_line(line0),
        .we(we0), .wr_idx(idx), .wr_line(wr_line)
    );

    cache_way_array #(.SETS(SETS)) u_way1 (
        .clk(clk), .rst(rst), .rd_idx(idx), .rd_line(line1),
        .we(we1), .wr_idx(idx), .wr_line(wr_line)
    );

    assign hit0 = line0.valid && (line0.tag == tag);
    assign hit1 = line1.valid && (line1.tag == tag);
    assign hit  = hit0 || hit1;

    always_comb begin
        rdata = '0;
        if (hit0)      rdata = word_sel ? line0.word1 : line0.word0;
        else if (hit1) rdata = word_sel ? line1.word1 : line1.word0;
    end

    always_comb begin
        state_d      = state_q;
        lru_d        = lru_q;
        fill_d       = fill_q;
        cache_freeze = 1'b0;
        sram_rd      = 1'b0;
        sram_wr      = 1'b0;
        sram_addr    = '0;
        sram_wdata   = '0;
        we0          = 1'b0;
        we1          = 1'b0;
        wr_line      = '0;
        unique case (state_q)
            ST_IDLE: begin
                // A simultaneous read+write request is treated as a write.
                if (MEM_W_en) begin
                    cache_freeze = 1'b1;
                    state_d      = ST_WRITE;
                end else if (MEM_R_en) begin
                    if (hit) begin
                        lru_d[idx] = hit0;
                    end else begin
                        cache_freeze = 1'b1;
                        state_d      = ST_FILL0;
                    end
                end
            end
            ST_FILL0: begin
                cache_freeze = 1'b1;
                sram_rd      = 1'b1;
                sram_addr    = {addr[31:3], 3'b000};
                if (sram_ready) begin
                    fill_d  = sram_rdata;
                    state_d = ST_FILL1;
                end
            end
            ST_FILL1: begin
                cache_freeze = 1'b1;
                sram_rd      = 1'b1;
                sram_addr    = {addr[31:3], 3'b100};
                if (sram_ready) begin
                    wr_line.valid = 1'b1;
                    wr_line.tag   = tag;
                    wr_line.word0 = fill_q;
                    wr_line.word1 = sram_rdata;
                    we0           = !lru_q[idx];
                    we1           = lru_q[idx];
                    lru_d[idx]    = !lru_q[idx];
                    state_d       = ST_IDLE;
                end
            end
            ST_WRITE: begin
                cache_freeze = 1'b1;
                sram_wr      = 1'b1;
                sram_addr    = {addr[31:2], 2'b00};
                sram_wdata   = wdata;
                if (sram_ready) begin
                    if (hit0) begin
                        wr_line    = put_word(line0, word_sel, wdata);
                        we0        = 1'b1;
                        lru_d[idx] = 1'b1;
                    end else if (hit1) begin
                        wr_line    = put_word(line1, word_sel, wdata);
                        we1        = 1'b1;
                        lru_d[idx] = 1'b0;
                    end
                    state_d = ST_WDONE;
                end
            end
            ST_WDONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lru_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            lru_q   <= lru_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_cache.sv
// Directed bench for mem_stage_cache with a latency-programmable SRAM responder.
module tb_mem_stage_cache;

    logic        clk, rst;
    logic        MEM_R_en, MEM_W_en;
    logic [31:0] addr, wdata, rdata;
    logic        cache_freeze, sram_rd, sram_wr;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic        sram_ready;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned lat     = 2;
    logic        resp_en = 1'b1;
    logic        busy    = 1'b0;
    int unsigned cnt     = 0;
    int unsigned wr_cnt  = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] rd_q [$];
    logic [31:0] wmem [logic [31:0]];

    mem_stage_cache #(.SETS(64)) dut (
        .clk(clk), .rst(rst), .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .cache_freeze(cache_freeze),
        .sram_rd(sram_rd), .sram_wr(sram_wr), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] exp_mem(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM model: ready pulses after lat wait cycles for each request.
    initial begin
        sram_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            sram_ready = 1'b0;
            if (!rst || !(sram_rd || sram_wr)) begin
                busy = 1'b0;
            end else if (resp_en) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = lat;
                end
                if (cnt == 0) begin
                    sram_ready = 1'b1;
                    busy       = 1'b0;
                    if (sram_rd) begin
                        sram_rdata = exp_mem(sram_addr);
                        rd_q.push_back(sram_addr);
                    end else begin
                        wmem[sram_addr] = sram_wdata;
                        wr_cnt++;
                        last_wr_addr = sram_addr;
                        last_wr_data = sram_wdata;
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the access retires.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int unsigned stalls, output logic [31:0] rd_val);
        int unsigned guard;
        MEM_R_en = r;
        MEM_W_en = w;
        addr     = a;
        wdata    = d;
        stalls   = 0;
        guard    = 0;
        forever begin
            @(negedge clk);
            if (!cache_freeze) break;
            stalls++;
            guard++;
            if (guard >= 200) begin
                check("freeze_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        rd_val = rdata;
        @(posedge clk);
        #1;
        MEM_R_en = 1'b0;
        MEM_W_en = 1'b0;
    endtask

    initial begin
        int unsigned st;
        logic [31:0] rv;
        int unsigned n0, w0, guard;

        rst = 1'b0; MEM_R_en = 1'b0; MEM_W_en = 1'b0; addr = '0; wdata = '0;
        #12;
        check("rst_freeze", 64'(cache_freeze), 64'd0);
        check("rst_sram_rd", 64'(sram_rd), 64'd0);
        check("rst_sram_wr", 64'(sram_wr), 64'd0);
        check("rst_sram_addr", 64'(sram_addr), 64'd0);
        check("rst_sram_wdata", 64'(sram_wdata), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Cold miss with two SRAM wait cycles, then hits on both words.
        lat = 2;
        n0 = rd_q.size();
        access(1'b1, 1'b0, 32'h40, '0, st, rv);
        check("miss_stalls", 64'(st), 64'd7);
        check("miss_nreads", 64'(rd_q.size() - n0), 64'd2);
        check("fill_addr0", 64'(rd_q[n0]), 64'h40);
        check("fill_addr1", 64'(rd_q[n0 + 1]), 64'h44);
        check("miss_rdata", 64'(rv), 64'(exp_mem(32'h40)));
        access(1'b1, 1'b0, 32'h40, '0, st, rv);
        check("hit_stalls", 64'(st), 64'd0);
        check("hit_rdata", 64'(rv), 64'(exp_mem(32'h40)));
        access(1'b1, 1'b0, 32'h44, '0, st, rv);
        check("hit_w1_stalls", 64'(st), 64'd0);
        check("hit_w1_rdata", 64'(rv), 64'(exp_mem(32'h44)));

        // LRU replacement within set 8 at zero SRAM latency.
        lat = 0;
        access(1'b1, 1'b0, 32'h240, '0, st, rv);
        check("way1_fill_stalls", 64'(st), 64'd3);
        check("way1_fill_rdata", 64'(rv), 64'(exp_mem(32'h240)));
        access(1'b1, 1'b0, 32'h40, '0, st, rv);
        check("touch40_stalls", 64'(st), 64'd0);
        access(1'b1, 1'b0, 32'h440, '0, st, rv);
        check("fill440_stalls", 64'(st), 64'd3);
        check("fill440_rdata", 64'(rv), 64'(exp_mem(32'h440)));
        access(1'b1, 1'b0, 32'h40, '0, st, rv);
        check("keep40_stalls", 64'(st), 64'd0);
        check("keep40_rdata", 64'(rv), 64'(exp_mem(32'h40)));
        access(1'b1, 1'b0, 32'h240, '0, st, rv);
        check("evicted240_stalls", 64'(st), 64'd3);

        // Write hit: write-through plus in-place update.
        lat = 2;
        w0 = wr_cnt;
        access(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, st, rv);
        check("whit_stalls", 64'(st), 64'd4);
        check("whit_nwrites", 64'(wr_cnt - w0), 64'd1);
        check("whit_addr", 64'(last_wr_addr), 64'h44);
        check("whit_data", 64'(last_wr_data), 64'hDEADBEEF);
        @(negedge clk);
        check("post_wdone_freeze", 64'(cache_freeze), 64'd0);
        check("post_wdone_nwrites", 64'(wr_cnt - w0), 64'd1);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h44, '0, st, rv);
        check("rd_after_w_stalls", 64'(st), 64'd0);
        check("rd_after_w_rdata", 64'(rv), 64'hDEADBEEF);
        access(1'b1, 1'b0, 32'h40, '0, st, rv);
        check("rd_other_word", 64'(rv), 64'(exp_mem(32'h40)));

        // Write miss: no allocation.
        lat = 0;
        n0 = rd_q.size();
        access(1'b0, 1'b1, 32'h800, 32'h12345678, st, rv);
        check("wmiss_stalls", 64'(st), 64'd2);
        check("wmiss_nreads", 64'(rd_q.size() - n0), 64'd0);
        check("wmiss_addr", 64'(last_wr_addr), 64'h800);
        access(1'b1, 1'b0, 32'h800, '0, st, rv);
        check("rd800_stalls", 64'(st), 64'd3);
        check("rd800_rdata", 64'(rv), 64'h12345678);

        // Reset asserted during FILL1.
        lat = 2;
        MEM_R_en = 1'b1;
        addr     = 32'h80;
        guard    = 0;
        forever begin
            @(negedge clk);
            if (sram_rd && sram_addr == 32'h84) break;
            guard++;
            if (guard >= 100) begin
                check("reach_fill1_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        #1 rst = 1'b0;
        #1 check("rstmid_sram_rd", 64'(sram_rd), 64'd0);
        MEM_R_en = 1'b0;
        #1 check("rstmid_freeze", 64'(cache_freeze), 64'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        n0 = rd_q.size();
        access(1'b1, 1'b0, 32'h80, '0, st, rv);
        check("refill80_stalls", 64'(st), 64'd7);
        check("refill80_nreads", 64'(rd_q.size() - n0), 64'd2);
        check("refill80_rdata", 64'(rv), 64'(exp_mem(32'h80)));
        lat = 0;
        access(1'b1, 1'b0, 32'h40, '0, st, rv);
        check("lost40_stalls", 64'(st), 64'd3);

        // SRAM holds off ready for 20 cycles in FILL0.
        resp_en  = 1'b0;
        MEM_R_en = 1'b1;
        addr     = 32'hC0;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_fill0", {31'd0, sram_rd, cache_freeze, sram_addr}, {31'd0, 1'b1, 1'b1, 32'hC0});
        end
        resp_en = 1'b1;
        guard   = 0;
        forever begin
            @(negedge clk);
            if (!cache_freeze) break;
            guard++;
            if (guard >= 100) begin
                check("hold_release_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        check("hold_rdata", 64'(rdata), 64'(exp_mem(32'hC0)));
        @(posedge clk); #1 MEM_R_en = 1'b0;
        @(negedge clk);
        check("idle_freeze", 64'(cache_freeze), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
